// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
// Also holds the operand magnitude helper.
package mul_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_op_e;

    // |v| when v is treated as signed; 0x80000000 maps onto itself.
    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] v,
        input logic            sgn
    );
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/iterative_mul_unit_if.sv
// Execute-stage request and result bundle.
// Master is the pipeline, slave is the multiplier.
interface iterative_mul_unit_if;
    import mul_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in, flush,
        input  busy, stall, valid, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in, flush,
        output busy, stall, valid, result, rd_out
    );

endinterface

// File: rtl/mul_sign_fix.sv
// Applies the product sign and picks the RV32M result half.
// Pure combinational; shared with the divider sign path.
module mul_sign_fix
    import mul_pkg::*;
(
    input  logic [2*XLEN-1:0] prod,
    input  logic              neg,
    input  mul_op_e           op,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] p;

    // Negate the magnitude product, then slice low or high word.
    always_comb begin
        p      = neg ? (~prod + 1'b1) : prod;
        result = (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/iterative_mul_unit.sv
// Radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Stalls the front end while iterating, then pulses valid once.
module iterative_mul_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    iterative_mul_unit_if.slave  bus
);
    import mul_pkg::*;

    localparam int CW = $clog2(ITER);

    mul_state_e      state_q;
    mul_state_e      state_d;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] res_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    mul_op_e         op_q;
    logic [4:0]      rd_pend_q;
    logic [4:0]      rd_q;

    logic            accept;
    logic            last;
    logic            s1;
    logic            s2;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] fixed;

    assign accept = (state_q == IDLE) && bus.start
                    && !bus.funct3[2] && !bus.flush;
    assign last   = (cnt_q == CW'(ITER - 1));

    assign s1  = (bus.funct3 == MULH) || (bus.funct3 == MULHSU);
    assign s2  = (bus.funct3 == MULH);
    assign sum = {1'b0, hi_q}
               + (lo_q[0] ? {1'b0, mcand_q} : '0);

    mul_sign_fix u_fix (
        .prod   ({hi_q, lo_q}),
        .neg    (neg_q),
        .op     (op_q),
        .result (fixed)
    );

    // While the result strobe is up, present the fresh product.
    assign bus.result = bus.valid ? fixed : res_q;
    assign bus.rd_out = bus.valid ? rd_pend_q : rd_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        bus.busy  = (state_q != IDLE);
        bus.stall = accept || (state_q == BUSY);
        bus.valid = (state_q == DONE) && !bus.flush;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator load, shift-add step and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            op_q      <= MUL;
            rd_pend_q <= '0;
            rd_q      <= '0;
            res_q     <= '0;
        end else begin
            if (accept) begin
                hi_q      <= '0;
                lo_q      <= mag(bus.rs2_data, s2);
                mcand_q   <= mag(bus.rs1_data, s1);
                cnt_q     <= '0;
                neg_q     <= (s1 & bus.rs1_data[XLEN-1])
                           ^ (s2 & bus.rs2_data[XLEN-1]);
                op_q      <= mul_op_e'({1'b0, bus.funct3[1:0]});
                rd_pend_q <= bus.rd_in;
            end else if (state_q == BUSY && !bus.flush) begin
                hi_q  <= sum[XLEN:1];
                lo_q  <= {sum[0], lo_q[XLEN-1:1]};
                cnt_q <= cnt_q + CW'(1);
            end
            if (bus.valid) begin
                res_q <= fixed;
                rd_q  <= rd_pend_q;
            end
        end
    end

endmodule

// File: tb/tb_iterative_mul_unit.sv
// Directed and random bench for iterative_mul_unit.
// Expected values come from a 64-bit arithmetic reference.
module tb_iterative_mul_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] res_model;
    logic [4:0]  rd_model;

    iterative_mul_unit_if mif ();

    iterative_mul_unit #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] p;
        sa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic set_idle();
        mif.start    = 1'b0;
        mif.funct3   = 3'd0;
        mif.rs1_data = 32'd0;
        mif.rs2_data = 32'd0;
        mif.rd_in    = 5'd0;
        mif.flush    = 1'b0;
    endtask

    // mode 0: plain, 1: start during BUSY, 2: flush, 3: reset
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int mode,
                          input int at);
        int vcount;
        int vfirst;
        int scount;
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        prev_res = res_model;
        prev_rd  = rd_model;
        vcount = 0;
        vfirst = 0;
        @(negedge clk);
        mif.start    = 1'b1;
        mif.funct3   = f3;
        mif.rs1_data = a;
        mif.rs2_data = b;
        mif.rd_in    = rd;
        #1;
        check("accept_stall", {31'd0, mif.stall}, 32'd1);
        scount = mif.stall ? 1 : 0;
        @(posedge clk);
        #1;
        mif.start    = 1'b0;
        mif.rs1_data = ~a;
        mif.rs2_data = ~b;
        mif.rd_in    = ~rd;
        for (int j = 1; j <= 40; j++) begin
            if (mif.stall) scount++;
            if (mif.valid) begin
                vcount++;
                if (vfirst == 0) vfirst = j;
                check("result", mif.result, exp);
                check("rd_out", {27'd0, mif.rd_out}, {27'd0, rd});
            end
            if (mode == 1 && j == at) begin
                mif.start    = 1'b1;
                mif.funct3   = 3'd0;
                mif.rs1_data = 32'd9;
                mif.rs2_data = 32'd9;
                mif.rd_in    = 5'd1;
            end
            if (mode == 1 && j == at + 1) mif.start = 1'b0;
            if (mode == 2 && j == at) mif.flush = 1'b1;
            if (mode == 2 && j == at + 1) begin
                mif.flush = 1'b0;
                check("flush_busy", {31'd0, mif.busy}, 32'd0);
                check("flush_res", mif.result, prev_res);
                check("flush_rd", {27'd0, mif.rd_out}, {27'd0, prev_rd});
            end
            if (mode == 3 && j == at) rst = 1'b0;
            if (mode == 3 && j == at + 1) begin
                check("rst_busy", {31'd0, mif.busy}, 32'd0);
                check("rst_stall", {31'd0, mif.stall}, 32'd0);
                check("rst_valid", {31'd0, mif.valid}, 32'd0);
                check("rst_res", mif.result, 32'd0);
                check("rst_rd", {27'd0, mif.rd_out}, 32'd0);
                rst = 1'b1;
            end
            if ((mode == 0 || mode == 1) && j == 34) begin
                check("idle_after", {31'd0, mif.busy}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (mode == 0 || mode == 1) begin
            check("valid_count", 32'(vcount), 32'd1);
            check("latency", 32'(vfirst), 32'd33);
            check("stall_cycles", 32'(scount), 32'd33);
            res_model = exp;
            rd_model  = rd;
        end else begin
            check("no_valid", 32'(vcount), 32'd0);
            if (mode == 3) begin
                res_model = 32'd0;
                rd_model  = 5'd0;
            end
            check("kept_res", mif.result, res_model);
        end
        set_idle();
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        set_idle();
        res_model = 32'd0;
        rd_model  = 5'd0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, mif.busy}, 32'd0);
        check("reset_stall", {31'd0, mif.stall}, 32'd0);
        check("reset_valid", {31'd0, mif.valid}, 32'd0);
        check("reset_result", mif.result, 32'd0);
        check("reset_rd", {27'd0, mif.rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'h0000002A, 0, 0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd3,
               32'h40000000, 0, 0);
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 5'd4,
               32'hFFFFFFFF, 0, 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,
               32'hFFFFFFFF, 0, 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,
               32'hFFFFFFFE, 0, 0);
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,
               32'h00000001, 0, 0);

        a = 32'd1234;
        b = 32'd5678;
        run_op(3'd0, a, b, 5'd9, ref_mul(3'd0, a, b), 1, 5);

        a = 32'hDEADBEEF;
        b = 32'h12345678;
        run_op(3'd1, a, b, 5'd10, ref_mul(3'd1, a, b), 2, 10);
        run_op(3'd0, 32'd3, 32'd5, 5'd11, 32'h0000000F, 0, 0);

        a = 32'h87654321;
        b = 32'hCAFEF00D;
        run_op(3'd2, a, b, 5'd12, ref_mul(3'd2, a, b), 3, 20);

        @(negedge clk);
        mif.start  = 1'b1;
        mif.funct3 = 3'b100;
        #1;
        check("nonmul_stall", {31'd0, mif.stall}, 32'd0);
        @(posedge clk);
        #1;
        check("nonmul_busy", {31'd0, mif.busy}, 32'd0);
        set_idle();

        @(negedge clk);
        mif.start  = 1'b1;
        mif.funct3 = 3'd0;
        mif.flush  = 1'b1;
        #1;
        check("flushstart_stall", {31'd0, mif.stall}, 32'd0);
        @(posedge clk);
        #1;
        check("flushstart_busy", {31'd0, mif.busy}, 32'd0);
        set_idle();

        repeat (12) begin
            f3 = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            run_op(f3, a, b, rd, ref_mul(f3, a, b), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iterative_mul_unit.md
# iterative_mul_unit

Radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It accepts one operation from the execute stage, raises a pipeline stall while it iterates, and then emits a one-cycle `valid` pulse with the 32-bit result. That `valid` pulse is the producer end of the `valid`/`valid_done` handshake consumed by the MEM/WB register.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `ITER`, 32: number of shift-add iterations. Must equal `XLEN`.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-low; sampled on posedge `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is not a multiply.
- `rs1_data`  in  32  multiplicand.
- `rs2_data`  in  32  multiplier.
- `rd_in`  in  5  destination register, latched at accept.
- `flush`  in  1  abort the current operation.
- `busy`  out  1  high in BUSY and DONE.
- `stall`  out  1  freezes IF/ID/EX; see Timing.
- `valid`  out  1  one-cycle result strobe.
- `result`  out  32  product slice; held stable after DONE until the next accept.
- `rd_out`  out  5  latched `rd_in`.

## Operation
- States (shared enum): IDLE, BUSY, DONE.
- IDLE to BUSY on `start` with `funct3[2]`=0:
  - latch `funct3` and `rd_in`;
  - form operand magnitudes: rs1 is treated as signed for MULH and MULHSU; rs2 is treated as signed for MULH only;
  - `neg` = XOR of the signs of the signed-treated operands;
  - load accumulator: `hi`=0, `lo`=|rs2|, `mcand`=|rs1|, `count`=0.
- |0x80000000| = 0x80000000 and is held as unsigned 32-bit. No overflow case exists.
- Each BUSY cycle:
  - `sum[32:0]` = `hi` + (`lo[0]` ? `mcand` : 0);
  - `{hi,lo}` <= `{sum,lo}` >> 1 (a 65-bit shift);
  - `count` increments.
- BUSY to DONE when `count`=ITER-1 is being processed.
- In DONE, the 64-bit product P = `neg` ? two's-complement of `{hi,lo}` : `{hi,lo}`.
- `result` selection:
  - MUL returns P[31:0] (the same for any signedness);
  - MULH, MULHSU and MULHU return P[63:32].
- DONE to IDLE unconditionally after one cycle.
- `start` is ignored outside IDLE. `start` with `funct3[2]`=1 is ignored: the unit stays in IDLE with no stall.
- `flush` in BUSY or DONE: next state is IDLE, `valid` is forced to 0 that cycle, and `result`/`rd_out` are not updated.
- `flush` and `start` in the same IDLE cycle: the start is dropped.

## Timing
- Reset (`rst`=0 at posedge): state=IDLE; `busy`=0, `stall`=0, `valid`=0, `result`=0, `rd_out`=0; accumulator and `count` cleared. Reset overrides everything, including mid-operation.
- `start` accepted at edge N:
  - BUSY during cycles N+1 through N+32;
  - DONE in cycle N+33, with `valid`=1, `result` and `rd_out` valid;
  - IDLE at N+34.
- Latency is 33 cycles from accept to `valid`, with no early termination for zero operands.
- `stall`:
  - combinational high in the accept cycle (IDLE with a qualifying `start`, no `flush`);
  - registered high throughout BUSY;
  - low in DONE, so the dependent instruction advances as the result is presented.
- `valid` is high in exactly one cycle per completed operation, never on two consecutive cycles.
- A new `start` is accepted at the earliest at edge N+34.

## Structure
- Package `mul_pkg`:
  - `mul_state_e` (IDLE/BUSY/DONE);
  - `mul_op_e` (MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011);
  - constants `XLEN`=32 and `ITER`=32.
- Top FSM plus counter sit in `iterative_mul_unit`.
- One sub-module, `mul_sign_fix`, holds the combinational negate-and-select: inputs `{hi,lo}`, `neg` and `op`; output `result`. It is reused by the sign handling of the future divider.

## Test plan
- MUL 7 × 6: `valid` exactly 33 cycles after accept, `result`=0x0000002A, `rd_out` equals `rd_in`, `stall` high for 33 cycles.
- MULH 0x80000000 × 0x80000000 gives 0x40000000. MULH 0xFFFFFFFF × 0x00000002 gives 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MUL on the same operands gives 0x00000001.
- A `start` pulsed in iteration 5: ignored. The original operation completes with a single `valid`, and the second request produces no extra stall.
- `flush` at iteration 10: IDLE next cycle, no `valid`, previous `result` retained. A fresh MUL 3 × 5 immediately after returns 0x0000000F.
- `rst`=0 at iteration 20: all outputs 0 on the next cycle, no `valid` ever for the aborted operation. `funct3`=3'b100 with `start` gives no `busy` and no `stall`.
